// File: rtl/vga_reg_arbiter.sv
// Round-robin arbiter sharing the VGA text controller register port
// between two masters. Each granted access produces a one-cycle
// chip-select strobe. The arbiter then waits for ready (or a timeout)
// and returns a one-cycle acknowledge to the master that was granted.
module vga_reg_arbiter #(
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req0,
  input  logic [7:0]  i_cmd0,
  input  logic [7:0]  i_data0,
  input  logic [10:0] i_cur0,
  input  logic        i_rlwh0,
  output logic        o_ack0,
  output logic        o_err0,
  input  logic        i_req1,
  input  logic [7:0]  i_cmd1,
  input  logic [7:0]  i_data1,
  input  logic [10:0] i_cur1,
  input  logic        i_rlwh1,
  output logic        o_ack1,
  output logic        o_err1,
  output logic [7:0]  o_rdata,
  output logic [7:0]  o_cmd,
  output logic [7:0]  o_port,
  output logic [10:0] o_cursor_adr,
  output logic        o_cs_h,
  output logic        o_rl_wh,
  input  logic        i_ready_h,
  input  logic [7:0]  i_port_rd
);

  // When the timeout is disabled the counter still needs at least one bit.
  localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {S_IDLE, S_STROBE, S_WAIT, S_ACK} state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_last;
  logic             r_sel;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ack0, r_ack1, r_err0, r_err1, r_cs;
  logic [7:0]       r_rdata, r_cmd, r_port;
  logic [10:0]      r_cur;
  logic             r_rlwh;
  logic             w_grant;
  logic             w_gsel;
  logic             w_timeout;

  // Grant selection: a tie goes to the requester that was not served last.
  always_comb begin
    w_grant   = i_req0 | i_req1;
    w_gsel    = (i_req0 & i_req1) ? ~r_last : i_req1;
    w_timeout = (TIMEOUT_CYC != 0) && (r_cnt == CNT_LAST);
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_grant) w_next = S_STROBE;
      S_STROBE: w_next = S_WAIT;
      S_WAIT:   if (i_ready_h || w_timeout) w_next = S_ACK;
      S_ACK:    w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Latch the granted access, drive the strobe, count the wait and
  // produce the acknowledge pulses.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last  <= 1'b1;
      r_sel   <= 1'b0;
      r_cnt   <= '0;
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
      r_err0  <= 1'b0;
      r_err1  <= 1'b0;
      r_cs    <= 1'b0;
      r_rdata <= '0;
      r_cmd   <= '0;
      r_port  <= '0;
      r_cur   <= '0;
      r_rlwh  <= 1'b0;
    end else begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      r_err0 <= 1'b0;
      r_err1 <= 1'b0;
      r_cs   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_sel  <= w_gsel;
            r_cmd  <= w_gsel ? i_cmd1  : i_cmd0;
            r_port <= w_gsel ? i_data1 : i_data0;
            r_cur  <= w_gsel ? i_cur1  : i_cur0;
            r_rlwh <= w_gsel ? i_rlwh1 : i_rlwh0;
            r_cs   <= 1'b1;
          end
        end
        S_STROBE: r_cnt <= '0;
        S_WAIT: begin
          if (i_ready_h) begin
            r_rdata <= i_port_rd;
            r_ack0  <= ~r_sel;
            r_ack1  <= r_sel;
          end else if (w_timeout) begin
            r_ack0 <= ~r_sel;
            r_ack1 <= r_sel;
            r_err0 <= ~r_sel;
            r_err1 <= r_sel;
          end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_ACK: r_last <= r_sel;
        default: ;
      endcase
    end
  end

  assign o_ack0       = r_ack0;
  assign o_ack1       = r_ack1;
  assign o_err0       = r_err0;
  assign o_err1       = r_err1;
  assign o_rdata      = r_rdata;
  assign o_cmd        = r_cmd;
  assign o_port       = r_port;
  assign o_cursor_adr = r_cur;
  assign o_cs_h       = r_cs;
  assign o_rl_wh      = r_rlwh;

endmodule

// File: tb/tb_vga_reg_arbiter.sv
// Scoreboard bench for vga_reg_arbiter: expected strobes and acks are
// queued by the stimulus and popped by an independent monitor.
module tb_vga_reg_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_req0, i_req1;
  logic [7:0]  i_cmd0, i_cmd1, i_data0, i_data1;
  logic [10:0] i_cur0, i_cur1;
  logic        i_rlwh0, i_rlwh1;
  logic        o_ack0, o_ack1, o_err0, o_err1;
  logic [7:0]  o_rdata, o_cmd, o_port;
  logic [10:0] o_cursor_adr;
  logic        o_cs_h, o_rl_wh;
  logic        i_ready_h;
  logic [7:0]  i_port_rd;

  always #5 i_clk = ~i_clk;

  vga_reg_arbiter #(.TIMEOUT_CYC(8)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req0(i_req0), .i_cmd0(i_cmd0), .i_data0(i_data0), .i_cur0(i_cur0),
    .i_rlwh0(i_rlwh0), .o_ack0(o_ack0), .o_err0(o_err0),
    .i_req1(i_req1), .i_cmd1(i_cmd1), .i_data1(i_data1), .i_cur1(i_cur1),
    .i_rlwh1(i_rlwh1), .o_ack1(o_ack1), .o_err1(o_err1),
    .o_rdata(o_rdata), .o_cmd(o_cmd), .o_port(o_port),
    .o_cursor_adr(o_cursor_adr), .o_cs_h(o_cs_h), .o_rl_wh(o_rl_wh),
    .i_ready_h(i_ready_h), .i_port_rd(i_port_rd)
  );

  typedef struct {
    logic [7:0]  cmd;
    logic [7:0]  data;
    logic [10:0] cur;
    logic        rlwh;
  } stb_t;

  typedef struct {
    logic       p;
    logic       err;
    logic       chk_rd;
    logic [7:0] rd;
  } ack_t;

  stb_t stb_q[$];
  ack_t ack_q[$];

  int checks   = 0;
  int failures = 0;

  logic       ctrl_en  = 1'b1;
  int         ctrl_dly = 1;
  logic [7:0] ctrl_rd  = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_txn(input logic p, input logic [7:0] cmd, input logic [7:0] data,
                            input logic [10:0] cur, input logic rlwh, input logic err,
                            input logic chk_rd, input logic [7:0] rd, input logic with_ack);
    stb_t s;
    ack_t a;
    s.cmd = cmd; s.data = data; s.cur = cur; s.rlwh = rlwh;
    stb_q.push_back(s);
    if (with_ack) begin
      a.p = p; a.err = err; a.chk_rd = chk_rd; a.rd = rd;
      ack_q.push_back(a);
    end
  endtask

  // Raise a request, wait (bounded) for its ack, then drop it.
  task automatic do_req(input logic p, input logic [7:0] cmd, input logic [7:0] data,
                        input logic [10:0] cur, input logic rlwh, output int lat);
    bit seen = 0;
    if (!p) begin
      i_cmd0 = cmd; i_data0 = data; i_cur0 = cur; i_rlwh0 = rlwh; i_req0 = 1'b1;
    end else begin
      i_cmd1 = cmd; i_data1 = data; i_cur1 = cur; i_rlwh1 = rlwh; i_req1 = 1'b1;
    end
    lat = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge i_clk);
      lat++;
      if ((p ? o_ack1 : o_ack0) === 1'b1) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL ack_wait_port%0d: got no ack expected ack within 60 cycles", p);
    end
    if (!p) i_req0 = 1'b0;
    else    i_req1 = 1'b0;
  endtask

  task automatic req_loop(input logic p, input int n);
    int lat;
    for (int i = 0; i < n; i++) begin
      if (i != 0) @(negedge i_clk);
      if (!p) do_req(1'b0, 8'h01, 8'h30 + 8'(i), 11'h000, 1'b1, lat);
      else    do_req(1'b1, 8'h04, 8'h80 + 8'(i), 11'h010, 1'b1, lat);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_cmd"},   32'(o_cmd), 0);
    chk({tag, "_port"},  32'(o_port), 0);
    chk({tag, "_cur"},   32'(o_cursor_adr), 0);
    chk({tag, "_cs"},    32'(o_cs_h), 0);
    chk({tag, "_rlwh"},  32'(o_rl_wh), 0);
    chk({tag, "_ack0"},  32'(o_ack0), 0);
    chk({tag, "_ack1"},  32'(o_ack1), 0);
    chk({tag, "_err0"},  32'(o_err0), 0);
    chk({tag, "_err1"},  32'(o_err1), 0);
    chk({tag, "_rdata"}, 32'(o_rdata), 0);
  endtask

  // Controller model: ready pulses ctrl_dly cycles after the strobe cycle.
  initial begin
    i_ready_h = 1'b0;
    i_port_rd = 8'h00;
    forever begin
      @(negedge i_clk);
      if (o_cs_h && ctrl_en && !i_rst) begin
        repeat (ctrl_dly) @(negedge i_clk);
        i_port_rd = ctrl_rd;
        i_ready_h = 1'b1;
        @(negedge i_clk);
        i_ready_h = 1'b0;
      end
    end
  end

  // Monitor: compares every strobe and every ack against the queues.
  initial begin
    logic cs_prev = 1'b0;
    stb_t s;
    ack_t a;
    forever begin
      @(negedge i_clk);
      if (o_cs_h) begin
        chk("cs_single_cycle", 32'(cs_prev), 0);
        if (stb_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_strobe: got cs_h=1 expected no strobe at %0t", $time);
        end else begin
          s = stb_q.pop_front();
          chk("stb_cmd",  32'(o_cmd), 32'(s.cmd));
          chk("stb_port", 32'(o_port), 32'(s.data));
          chk("stb_cur",  32'(o_cursor_adr), 32'(s.cur));
          chk("stb_rlwh", 32'(o_rl_wh), 32'(s.rlwh));
        end
      end
      cs_prev = o_cs_h;
      if (o_ack0 && o_ack1) chk("ack_onehot", 32'({o_ack1, o_ack0}), 32'h1);
      if (o_err0 && !o_ack0) chk("err0_without_ack", 32'(o_err0), 0);
      if (o_err1 && !o_ack1) chk("err1_without_ack", 32'(o_err1), 0);
      if (o_ack0 || o_ack1) begin
        if (ack_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_ack: got ack0=%0b ack1=%0b expected none at %0t",
                   o_ack0, o_ack1, $time);
        end else begin
          a = ack_q.pop_front();
          chk("ack_port", 32'(o_ack1), 32'(a.p));
          chk("ack_err", 32'(a.p ? o_err1 : o_err0), 32'(a.err));
          if (a.chk_rd) chk("ack_rdata", 32'(o_rdata), 32'(a.rd));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish within 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    i_rst = 1'b1;
    i_req0 = 0; i_cmd0 = 0; i_data0 = 0; i_cur0 = 0; i_rlwh0 = 0;
    i_req1 = 0; i_cmd1 = 0; i_data1 = 0; i_cur1 = 0; i_rlwh1 = 0;
    repeat (3) @(negedge i_clk);
    check_zero("reset");
    i_rst = 1'b0;
    @(negedge i_clk);

    // Contention from reset: alternating grants starting with requester 0.
    ctrl_dly = 1;
    for (int i = 0; i < 4; i++) begin
      expect_txn(1'b0, 8'h01, 8'h30 + 8'(i), 11'h000, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
      expect_txn(1'b1, 8'h04, 8'h80 + 8'(i), 11'h010, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    end
    fork
      req_loop(1'b0, 4);
      req_loop(1'b1, 4);
    join
    @(negedge i_clk);
    chk("contention_stb_drained", 32'(stb_q.size()), 0);

    // Single write, ready 3 cycles after the strobe.
    ctrl_dly = 3; ctrl_rd = 8'h11;
    expect_txn(1'b0, 8'h01, 8'h41, 11'h000, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    do_req(1'b0, 8'h01, 8'h41, 11'h000, 1'b1, lat);
    chk("write_latency", 32'(lat), 5);
    @(negedge i_clk);

    // Read on requester 1.
    ctrl_rd = 8'h5A;
    expect_txn(1'b1, 8'h00, 8'h00, 11'h000, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b1);
    do_req(1'b1, 8'h00, 8'h00, 11'h000, 1'b0, lat);
    chk("read_latency", 32'(lat), 5);
    @(negedge i_clk);

    // Timeout: ready never comes, rdata stays at the previous read value.
    ctrl_en = 1'b0;
    expect_txn(1'b0, 8'h02, 8'h77, 11'h012, 1'b1, 1'b1, 1'b1, 8'h5A, 1'b1);
    do_req(1'b0, 8'h02, 8'h77, 11'h012, 1'b1, lat);
    chk("timeout_latency", 32'(lat), 10);
    @(negedge i_clk);
    ctrl_en = 1'b1;

    // Cursor write served normally after the timeout; outputs hold after ack.
    ctrl_dly = 2; ctrl_rd = 8'h22;
    expect_txn(1'b0, 8'h03, 8'h00, 11'h320, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    do_req(1'b0, 8'h03, 8'h00, 11'h320, 1'b1, lat);
    chk("cursor_latency", 32'(lat), 4);
    repeat (3) @(negedge i_clk);
    chk("cursor_hold", 32'(o_cursor_adr), 32'h320);
    chk("cmd_hold", 32'(o_cmd), 32'h03);
    chk("rdata_hold", 32'(o_rdata), 32'h22);

    // Reset while waiting for ready: no ack, then a fresh request completes.
    ctrl_en = 1'b0;
    expect_txn(1'b0, 8'h01, 8'h55, 11'h005, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    i_cmd0 = 8'h01; i_data0 = 8'h55; i_cur0 = 11'h005; i_rlwh0 = 1'b1; i_req0 = 1'b1;
    repeat (3) @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    check_zero("midrst");
    i_rst = 1'b0;
    i_req0 = 1'b0;
    repeat (12) @(negedge i_clk);
    ctrl_en = 1'b1; ctrl_dly = 1; ctrl_rd = 8'h66;
    expect_txn(1'b1, 8'h04, 8'h9C, 11'h100, 1'b1, 1'b0, 1'b1, 8'h66, 1'b1);
    do_req(1'b1, 8'h04, 8'h9C, 11'h100, 1'b1, lat);
    chk("post_reset_latency", 32'(lat), 3);
    repeat (4) @(negedge i_clk);

    chk("stb_queue_empty", 32'(stb_q.size()), 0);
    chk("ack_queue_empty", 32'(ack_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
